// File: rtl/clockport_target.sv
// Amiga clockport responder: four byte registers over Amiga->Pi (TX) and Pi->Amiga (RX) FIFOs.
// Optional macro CP_TARGET_IRQ_EN adds the CONTROL register and the INT6 request.
module clockport_target #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cp_cs_n,
    input  logic       cp_iord_n,
    input  logic       cp_iowr_n,
    input  logic [1:0] cp_a,
    input  logic [7:0] cp_d_in,
    output logic [7:0] cp_d_out,
    output logic       cp_d_oe,
    output logic       cp_int6_oe,
    input  logic [7:0] pi_rx_data,
    input  logic       pi_rx_valid,
    output logic       pi_rx_ready,
    output logic [7:0] pi_tx_data,
    output logic       pi_tx_valid,
    input  logic       pi_tx_ready
);
    // state | meaning
    // HOLD  | after reset or a bad strobe combination; wait for chip select release
    // IDLE  | waiting for a qualified read or write strobe
    // READ  | driving the snapshotted byte; pop side effect on strobe release
    // WRITE | waiting for strobe release to commit the write data
    typedef enum logic [1:0] {ST_HOLD, ST_IDLE, ST_READ, ST_WRITE} state_t;

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = 1;
    localparam logic [1:0]  A_DATA     = 2'd0;
    localparam logic [1:0]  A_STATUS   = 2'd1;
    localparam logic [1:0]  A_CONTROL  = 2'd2;
    localparam logic [1:0]  A_RX_COUNT = 2'd3;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync;
    logic [1:0]             a_sync [SYNC_STAGES];
    logic [7:0]             d_sync [SYNC_STAGES];
    logic                   s_cs, s_rd, s_wr;
    logic [1:0]             s_a;
    logic [7:0]             s_d;

    // Strobe chains reset to "asserted" so HOLD cannot exit until a real release is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync <= '0;
            rd_sync <= '0;
            wr_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '0;
                d_sync[i] <= '0;
            end
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cp_cs_n};
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], cp_iord_n};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], cp_iowr_n};
            a_sync[0] <= cp_a;
            d_sync[0] <= cp_d_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    assign s_cs = ~cs_sync[SYNC_STAGES-1];
    assign s_rd = ~rd_sync[SYNC_STAGES-1];
    assign s_wr = ~wr_sync[SYNC_STAGES-1];
    assign s_a  = a_sync[SYNC_STAGES-1];
    assign s_d  = d_sync[SYNC_STAGES-1];

    state_t     state_q, state_nxt;
    logic       oe_reg, rd_pop_q, rd_under_q, overrun_q, underrun_q, int6_q;
    logic       rd_load, oe_clr, pop_go, under_go, wr_go;
    logic [7:0] rd_mux;
    logic [1:0] ctrl;
    logic       irq;

    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp, rx_count;
    logic        rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]  rx_head, rx_cnt_sat;
    logic [8:0]  rx_cnt9;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_full, tx_empty, tx_push, tx_pop;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_push  = pi_rx_valid && !rx_full;
    assign rx_pop   = pop_go && !rx_empty;
    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
    assign rx_count = rx_wp - rx_rp;
    assign rx_cnt9  = 9'(rx_count);
    assign rx_cnt_sat = rx_cnt9[8] ? 8'hFF : rx_cnt9[7:0];

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_push  = wr_go && (s_a == A_DATA) && !tx_full;
    assign tx_pop   = pi_tx_ready && !tx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= pi_rx_data;
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= s_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wp <= '0;
            rx_rp <= '0;
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
            if (tx_push) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
        end
    end

`ifdef CP_TARGET_IRQ_EN
    logic [1:0] ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl_q <= 2'b00;
        else if (wr_go && s_a == A_CONTROL)
            ctrl_q <= s_d[1:0];
    end

    assign ctrl = ctrl_q;
    assign irq  = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
`else
    assign ctrl = 2'b00;
    assign irq  = 1'b0;
`endif

    always_comb begin
        rd_mux = 8'h00;
        case (s_a)
            A_DATA:     rd_mux = rx_head;
            A_STATUS:   rd_mux = {irq, 2'b00, tx_empty, underrun_q, overrun_q, tx_full, ~rx_empty};
            A_CONTROL:  rd_mux = {6'b000000, ctrl};
            A_RX_COUNT: rd_mux = rx_cnt_sat;
            default:    rd_mux = 8'h00;
        endcase
    end

    // Strobe release wins over a simultaneous chip-select release so normal cycles complete.
    always_comb begin
        state_nxt = state_q;
        rd_load   = 1'b0;
        oe_clr    = 1'b0;
        pop_go    = 1'b0;
        under_go  = 1'b0;
        wr_go     = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (!s_cs) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_rd && s_wr) begin
                    state_nxt = ST_HOLD;
                end else if (s_cs && s_rd) begin
                    state_nxt = ST_READ;
                    rd_load   = 1'b1;
                end else if (s_cs && s_wr) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_READ: begin
                if (!s_rd) begin
                    state_nxt = ST_IDLE;
                    oe_clr    = 1'b1;
                    pop_go    = rd_pop_q;
                    under_go  = rd_under_q;
                end else if (!s_cs) begin
                    state_nxt = ST_IDLE;
                    oe_clr    = 1'b1;
                end
            end
            ST_WRITE: begin
                if (!s_wr) begin
                    state_nxt = ST_IDLE;
                    wr_go     = 1'b1;
                end else if (!s_cs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            oe_reg     <= 1'b0;
            cp_d_out   <= 8'h00;
            rd_pop_q   <= 1'b0;
            rd_under_q <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            int6_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            int6_q  <= irq;
            if (rd_load) begin
                cp_d_out   <= rd_mux;
                oe_reg     <= 1'b1;
                rd_pop_q   <= (s_a == A_DATA) && !rx_empty;
                rd_under_q <= (s_a == A_DATA) && rx_empty;
            end
            if (oe_clr)   oe_reg     <= 1'b0;
            if (under_go) underrun_q <= 1'b1;
            if (wr_go && s_a == A_DATA && tx_full) overrun_q <= 1'b1;
            if (wr_go && s_a == A_STATUS) begin
                if (s_d[2]) overrun_q  <= 1'b0;
                if (s_d[3]) underrun_q <= 1'b0;
            end
        end
    end

    assign cp_d_oe     = oe_reg & ~cp_cs_n & ~cp_iord_n;
    assign cp_int6_oe  = int6_q;
    assign pi_rx_ready = ~rx_full;
    assign pi_tx_valid = ~tx_empty;
    assign pi_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[AW-1:0]];

endmodule

// File: tb/tb_clockport_target.sv
// Scoreboard bench for clockport_target: host reads and Pi-side TX pops are checked
// by a negedge monitor against queues of expected bytes filled by the stimulus.
module tb_clockport_target;
    localparam int DEPTH = 16;
    localparam int SS    = 2;
`ifdef CP_TARGET_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CONTROL = 2'd2, A_RX_COUNT = 2'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cp_cs_n, cp_iord_n, cp_iowr_n;
    logic [1:0] cp_a;
    logic [7:0] cp_d_in, cp_d_out;
    logic       cp_d_oe, cp_int6_oe;
    logic [7:0] pi_rx_data, pi_tx_data;
    logic       pi_rx_valid, pi_rx_ready, pi_tx_valid, pi_tx_ready;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];
    logic       prev_oe = 1'b0;
    logic       oe_seen;

    clockport_target #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset),
        .cp_cs_n(cp_cs_n), .cp_iord_n(cp_iord_n), .cp_iowr_n(cp_iowr_n),
        .cp_a(cp_a), .cp_d_in(cp_d_in), .cp_d_out(cp_d_out), .cp_d_oe(cp_d_oe),
        .cp_int6_oe(cp_int6_oe),
        .pi_rx_data(pi_rx_data), .pi_rx_valid(pi_rx_valid), .pi_rx_ready(pi_rx_ready),
        .pi_tx_data(pi_tx_data), .pi_tx_valid(pi_tx_valid), .pi_tx_ready(pi_tx_ready)
    );

    always #25 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Monitor: a host read is presented when cp_d_oe rises; a TX byte when valid & ready.
    always @(negedge clk) begin
        if (cp_d_oe && !prev_oe) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got 0x%02h expected no read", cp_d_out);
            end else begin
                check("read_data", cp_d_out, rd_q.pop_front());
            end
        end
        prev_oe = cp_d_oe;
        if (pi_tx_valid && pi_tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx: got 0x%02h expected no byte", pi_tx_data);
            end else begin
                check("tx_data", pi_tx_data, tx_q.pop_front());
            end
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cp_a = a; cp_d_in = d; cp_cs_n = 1'b0; cp_iowr_n = 1'b0;
        #600;
        cp_iowr_n = 1'b1;
        #150;
        cp_cs_n = 1'b1;
        #200;
    endtask

    task automatic host_read(input logic [1:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        @(posedge clk); #1;
        cp_a = a; cp_cs_n = 1'b0; cp_iord_n = 1'b0;
        #600;
        cp_iord_n = 1'b1;
        #50;
        cp_cs_n = 1'b1;
        #200;
    endtask

    task automatic pi_push(input logic [7:0] d);
        @(posedge clk); #1;
        pi_rx_data = d; pi_rx_valid = 1'b1;
        @(posedge clk); #1;
        pi_rx_valid = 1'b0;
    endtask

    task automatic pi_pop_one();
        @(posedge clk); #1;
        pi_tx_ready = 1'b1;
        @(posedge clk); #1;
        pi_tx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cp_cs_n = 1'b1; cp_iord_n = 1'b1; cp_iowr_n = 1'b1;
        cp_a = 2'd0; cp_d_in = 8'h00;
        pi_rx_data = 8'h00; pi_rx_valid = 1'b0; pi_tx_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_d_out", cp_d_out, 8'h00);
        check("rst_d_oe", {7'b0, cp_d_oe}, 8'h00);
        check("rst_int6", {7'b0, cp_int6_oe}, 8'h00);
        check("rst_rx_ready", {7'b0, pi_rx_ready}, 8'h01);
        check("rst_tx_valid", {7'b0, pi_tx_valid}, 8'h00);
        check("rst_tx_data", pi_tx_data, 8'h00);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Host writes reach the Pi in order.
        host_write(A_DATA, 8'hA5); tx_q.push_back(8'hA5);
        host_write(A_DATA, 8'h3C); tx_q.push_back(8'h3C);
        check("tx_valid_after_writes", {7'b0, pi_tx_valid}, 8'h01);
        pi_pop_one();
        pi_pop_one();
        #1 check("tx_empty_after_pops", {7'b0, pi_tx_valid}, 8'h00);

        // RX path, underrun and W1C.
        pi_push(8'h11);
        pi_push(8'h22);
        host_read(A_RX_COUNT, 8'h02);
        host_read(A_DATA, 8'h11);
        host_read(A_DATA, 8'h22);
        host_read(A_DATA, 8'h00);
        host_read(A_STATUS, 8'h18);
        host_write(A_STATUS, 8'h08);
        host_read(A_STATUS, 8'h10);

        // Fill TX past full: overrun set, extra byte dropped.
        for (int i = 0; i < DEPTH; i++) begin
            host_write(A_DATA, 8'(i + 8'h40));
            tx_q.push_back(8'(i + 8'h40));
        end
        host_write(A_DATA, 8'hEE);
        host_read(A_STATUS, 8'h06);
        for (int i = 0; i < DEPTH; i++) pi_pop_one();
        #1 check("tx_extra_absent", {7'b0, pi_tx_valid}, 8'h00);
        host_write(A_STATUS, 8'h04);
        host_read(A_STATUS, 8'h10);

        // CONTROL and INT6.
        host_write(A_CONTROL, 8'h01);
        host_read(A_CONTROL, IRQ_EN ? 8'h01 : 8'h00);
        pi_push(8'h5A);
        repeat (3) @(posedge clk); #1;
        check("int6_rx_pending", {7'b0, cp_int6_oe}, {7'b0, IRQ_EN});
        host_read(A_STATUS, IRQ_EN ? 8'h91 : 8'h11);
        rd_q.push_back(8'h5A);
        @(posedge clk); #1;
        cp_a = A_DATA; cp_cs_n = 1'b0; cp_iord_n = 1'b0;
        #600;
        cp_iord_n = 1'b1;
        repeat (SS + 2) @(posedge clk); #1;
        check("int6_cleared_after_pop", {7'b0, cp_int6_oe}, 8'h00);
        cp_cs_n = 1'b1;
        #200;
        host_write(A_CONTROL, 8'h00);

        // Reset in the middle of a read.
        pi_push(8'h77);
        pi_push(8'h88);
        rd_q.push_back(8'h77);
        @(posedge clk); #1;
        cp_a = A_DATA; cp_cs_n = 1'b0; cp_iord_n = 1'b0;
        repeat (8) @(posedge clk); #1;
        check("oe_during_read", {7'b0, cp_d_oe}, 8'h01);
        reset = 1'b1;
        #1 check("oe_async_reset", {7'b0, cp_d_oe}, 8'h00);
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("oe_held_in_hold", {7'b0, cp_d_oe}, 8'h00);
        cp_iord_n = 1'b1;
        #50 cp_cs_n = 1'b1;
        #300;
        host_read(A_RX_COUNT, 8'h00);
        pi_push(8'h99);
        host_read(A_DATA, 8'h99);
        host_read(A_RX_COUNT, 8'h00);

        // Read and write strobes together: no side effects, no drive.
        pi_push(8'h44);
        @(posedge clk); #1;
        cp_a = A_DATA; cp_d_in = 8'hFF; cp_cs_n = 1'b0; cp_iord_n = 1'b0; cp_iowr_n = 1'b0;
        oe_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cp_d_oe) oe_seen = 1'b1;
        end
        check("oe_dual_strobe", {7'b0, oe_seen}, 8'h00);
        @(posedge clk); #1;
        cp_iord_n = 1'b1; cp_iowr_n = 1'b1;
        #100 cp_cs_n = 1'b1;
        #200;
        host_read(A_RX_COUNT, 8'h01);
        host_read(A_STATUS, 8'h11);
        check("tx_untouched_dual", {7'b0, pi_tx_valid}, 8'h00);
        host_read(A_DATA, 8'h44);

        repeat (5) @(posedge clk);
        check("reads_all_seen", 8'(rd_q.size()), 8'h00);
        check("tx_all_seen", 8'(tx_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
